// File: rtl/sccb_slave_regfile.sv
// SCCB (I2C-like) slave with a 256x8 register file: sub-address pointer,
// burst writes, sequential reads and a combinational debug peek port.
module sccb_slave_regfile #(
    parameter logic [6:0]  DEV_ID      = 7'h21,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ID, ACK_ID, SUB, ACK_SUB, WDATA, ACK_W, RDATA, MACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       ack_ph_q, ack_ph_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] mem_q [256];
    logic [7:0] byte_in, rd_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign byte_in = {shift_q[6:0], sda_s};
    assign rd_byte = mem_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        ack_ph_d  = ack_ph_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_ev) begin
            state_d  = IDLE;
            oe_d     = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
        end else if (start_ev) begin
            state_d  = ID;
            oe_d     = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
        end else begin
            case (state_q)
                ID, SUB, WDATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (state_q == ID) begin
                                rw_d    = sda_s;
                                state_d = (byte_in[7:1] == DEV_ID) ? ACK_ID : WAIT_STOP;
                            end else if (state_q == SUB) begin
                                ptr_d   = byte_in;
                                state_d = ACK_SUB;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                                state_d   = ACK_W;
                            end
                        end
                    end
                end
                ACK_ID, ACK_SUB, ACK_W: begin
                    // First fall starts driving ACK, second fall ends the ACK period.
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            oe_d     = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            oe_d     = 1'b0;
                            ack_ph_d = 1'b0;
                            cnt_d    = '0;
                            if (state_q == ACK_ID) begin
                                if (rw_q) begin
                                    state_d = RDATA;
                                    oe_d    = ~rd_byte[7];
                                    cnt_d   = 4'd1;
                                end else begin
                                    state_d = SUB;
                                end
                            end else begin
                                if (state_q == ACK_W) ptr_d = ptr_q + 8'd1;
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = MACK;
                        end else begin
                            oe_d  = ~rd_byte[~cnt_q[2:0]];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_q + 8'd1;
                            cnt_d   = '0;
                            state_d = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            ack_ph_q  <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            ack_ph_q  <= ack_ph_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 256; i++) mem_q[i] <= '0;
        end else if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign sda_oe   = oe_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile: bit-banged SCCB master on an
// open-drain SDA line, table-driven writes plus multi-cycle corner sequences.
module tb_sccb_slave_regfile;

    localparam time Q = 100ns;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    logic [7:0] last_a = '0, last_d = '0;
    logic oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    sccb_slave_regfile #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
    );

    always #5ns clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt = wr_cnt + 1;
            last_a = wr_addr;
            last_d = wr_data;
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(~mack);
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] v);
        dbg_addr = a; #1;
        v = dbg_data;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wvec_t;

    initial begin
        wvec_t vecs[4];
        logic ack;
        logic [7:0] rv;
        logic [8:0] tail;
        int base;

        vecs[0] = '{addr: 8'h12, data: 8'h80};
        vecs[1] = '{addr: 8'h0C, data: 8'hD0};
        vecs[2] = '{addr: 8'h00, data: 8'h5A};
        vecs[3] = '{addr: 8'h7F, data: 8'h01};

        dbg_addr = 8'h00;
        #200ns;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", wr_addr, 0);
        peek(8'hFF, rv); check("rst_mem_ff", rv, 8'h00);
        rst_n = 1'b1;
        #(4 * Q);

        for (int k = 0; k < 4; k++) begin
            base = wr_cnt;
            bus_start();
            check("wr_busy", busy, 1);
            write_byte(8'h42, ack); check("wr_ack_id", ack, 1);
            write_byte(vecs[k].addr, ack); check("wr_ack_sub", ack, 1);
            write_byte(vecs[k].data, ack); check("wr_ack_data", ack, 1);
            bus_stop();
            check("wr_pulses", wr_cnt - base, 1);
            check("wr_addr", last_a, vecs[k].addr);
            check("wr_data", last_d, vecs[k].data);
            check("wr_busy_end", busy, 0);
        end
        for (int k = 0; k < 4; k++) begin
            peek(vecs[k].addr, rv);
            check("peek_table", rv, vecs[k].data);
        end

        // Wrong device ID
        base = wr_cnt;
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'h60, ack); check("badid_ack", ack, 0);
        write_byte(8'h12, ack);
        write_byte(8'h33, ack);
        check("badid_busy", busy, 1);
        bus_stop();
        check("badid_oe_seen", oe_seen, 0);
        check("badid_pulses", wr_cnt - base, 0);
        check("badid_busy_end", busy, 0);
        peek(8'h12, rv); check("badid_mem", rv, 8'h80);

        // Pointer set by write, repeated START, read, NACK then WAIT_STOP
        bus_start();
        write_byte(8'h42, ack); check("rd_ack_id", ack, 1);
        write_byte(8'h0C, ack); check("rd_ack_sub", ack, 1);
        bus_start();
        write_byte(8'h43, ack); check("rd_ack_rid", ack, 1);
        read_byte(1'b0, rv); check("rd_data", rv, 8'hD0);
        for (int i = 8; i >= 0; i--) begin
            logic b;
            read_bit(b);
            tail[i] = b;
        end
        check("rd_waitstop_released", tail, 9'h1FF);
        check("rd_waitstop_busy", busy, 1);
        bus_stop();
        check("rd_busy_end", busy, 0);

        // Burst write with pointer wrap, then burst read across the wrap
        base = wr_cnt;
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack); check("burst_ack1", ack, 1);
        write_byte(8'h22, ack); check("burst_ack2", ack, 1);
        bus_stop();
        check("burst_pulses", wr_cnt - base, 2);
        peek(8'hFF, rv); check("burst_mem_ff", rv, 8'h11);
        peek(8'h00, rv); check("burst_mem_00", rv, 8'h22);
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'hFF, ack);
        bus_start();
        write_byte(8'h43, ack);
        read_byte(1'b1, rv); check("burst_rd0", rv, 8'h11);
        read_byte(1'b1, rv); check("burst_rd1", rv, 8'h22);
        read_byte(1'b0, rv); check("burst_rd2", rv, 8'h00);
        bus_stop();

        // Abort a data byte after 5 bits
        base = wr_cnt;
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'h30, ack);
        for (int i = 0; i < 5; i++) write_bit(i[0]);
        bus_stop();
        check("abort_pulses", wr_cnt - base, 0);
        peek(8'h30, rv); check("abort_mem", rv, 8'h00);
        check("abort_busy", busy, 0);
        oe_seen = 1'b0;
        scl_m = 1'b0; #Q;
        for (int i = 0; i < 9; i++) write_bit(1'b0);
        check("abort_idle_quiet", oe_seen, 0);
        bus_stop();

        // Reset while slave drives a 0 data bit
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'h40, ack);
        write_byte(8'h0F, ack);
        bus_start();
        write_byte(8'h42, ack);
        write_byte(8'h40, ack);
        bus_start();
        write_byte(8'h43, ack);
        check("rstrd_driving0", sda_oe, 1);
        rst_n = 1'b0; #1;
        check("rstrd_oe_released", sda_oe, 0);
        #(2 * Q);
        peek(8'h40, rv); check("rstrd_mem_cleared", rv, 8'h00);
        rst_n = 1'b1;
        base = wr_cnt;
        oe_seen = 1'b0;
        for (int i = 0; i < 10; i++) write_bit(i[1]);
        check("rstrd_quiet", oe_seen, 0);
        check("rstrd_busy", busy, 0);
        check("rstrd_pulses", wr_cnt - base, 0);
        bus_stop();
        bus_start();
        write_byte(8'h43, ack); check("rstrd_new_ack", ack, 1);
        read_byte(1'b0, rv); check("rstrd_new_data", rv, 8'h00);
        bus_stop();
        check("rstrd_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
